// File: rtl/icache_pkg.sv
// Shared types and sizing for the direct-mapped instruction cache.
// Defines the controller state encoding and default geometry.
package icache_pkg;

  localparam int ADDR_WIDTH      = 32;
  localparam int INST_WIDTH      = 32;
  localparam int DEF_INDEX_BITS  = 4;
  localparam int DEF_OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    ICACHE_IDLE   = 2'd0,
    ICACHE_REFILL = 2'd1,
    ICACHE_COOL   = 2'd2
  } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// The cache uses the slave view; ifetch/memory models use the master view.
interface icache_if #(
  parameter int LINE_BITS = 128
) ();
  import icache_pkg::*;

  logic [ADDR_WIDTH-1:0] next_PC;
  logic                  next_inst;
  logic                  flush;
  logic                  inst_rdy;
  logic [INST_WIDTH-1:0] inst_out;
  logic                  mc_req;
  logic [ADDR_WIDTH-1:0] mc_addr;
  logic                  mc_line_rdy;
  logic [LINE_BITS-1:0]  mc_line;

  modport slave (
    input  next_PC, next_inst, flush, mc_line_rdy, mc_line,
    output inst_rdy, inst_out, mc_req, mc_addr
  );

  modport master (
    output next_PC, next_inst, flush, mc_line_rdy, mc_line,
    input  inst_rdy, inst_out, mc_req, mc_addr
  );

endinterface

// File: rtl/icache_extract.sv
// Picks the 32-bit little-endian word starting at a halfword offset out of
// the concatenation {hi_line, lo_line}, so straddling fetches come for free.
module icache_extract
  import icache_pkg::*;
#(
  parameter int OFFSET_BITS = DEF_OFFSET_BITS,
  parameter int LINE_BITS   = 8 * (2 ** OFFSET_BITS)
) (
  input  logic [LINE_BITS-1:0]   lo_line,
  input  logic [LINE_BITS-1:0]   hi_line,
  input  logic [OFFSET_BITS-1:0] offset,
  output logic [INST_WIDTH-1:0]  word
);

  logic [2*LINE_BITS-1:0] pair;
  assign pair = {hi_line, lo_line};

  genvar gi;
  generate
    for (gi = 0; gi < INST_WIDTH / 8; gi++) begin : g_byte
      logic [OFFSET_BITS:0] pos;
      assign pos = {1'b0, offset} + (OFFSET_BITS + 1)'(gi);
      assign word[gi*8 +: 8] = pair[{pos, 3'b000} +: 8];
    end
  endgenerate

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with whole-line refill.
// A fetch crossing a line boundary is served only when both lines hit.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS  = DEF_INDEX_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
  input logic     clk,
  input logic     rst_in,
  input logic     rdy_in,
  icache_if.slave bus
);

  localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int LINES     = 2 ** INDEX_BITS;
  localparam int LINE_BITS = 8 * (2 ** OFFSET_BITS);
  localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(2 ** OFFSET_BITS);

  logic [TAG_BITS-1:0]  tag_mem  [LINES];
  logic [LINE_BITS-1:0] data_mem [LINES];
  logic [LINES-1:0]     valid_reg;

  icache_state_e         state_reg, state_next;
  logic                  inst_rdy_reg, inst_rdy_next;
  logic [INST_WIDTH-1:0] inst_out_reg, inst_out_next;
  logic                  mc_req_reg, mc_req_next;
  logic [ADDR_WIDTH-1:0] mc_addr_reg, mc_addr_next;
  logic                  install;

  logic [ADDR_WIDTH-1:0] pc, lo_addr, hi_addr;
  logic [INDEX_BITS-1:0] lo_idx, hi_idx, fill_idx;
  logic [TAG_BITS-1:0]   lo_tag, hi_tag, fill_tag;
  logic                  straddle, lo_hit, hi_hit;
  logic [INST_WIDTH-1:0] word;

  // Bit 0 of the PC is meaningless for halfword-aligned fetch.
  assign pc       = {bus.next_PC[ADDR_WIDTH-1:1], 1'b0};
  assign lo_addr  = {pc[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign straddle = &pc[OFFSET_BITS-1:1];
  assign hi_addr  = straddle ? lo_addr + LINE_BYTES : lo_addr;

  assign lo_idx   = lo_addr[OFFSET_BITS +: INDEX_BITS];
  assign hi_idx   = hi_addr[OFFSET_BITS +: INDEX_BITS];
  assign lo_tag   = lo_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign hi_tag   = hi_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign fill_idx = mc_addr_reg[OFFSET_BITS +: INDEX_BITS];
  assign fill_tag = mc_addr_reg[ADDR_WIDTH-1 -: TAG_BITS];

  assign lo_hit = valid_reg[lo_idx] && (tag_mem[lo_idx] == lo_tag);
  assign hi_hit = valid_reg[hi_idx] && (tag_mem[hi_idx] == hi_tag);

  icache_extract #(
    .OFFSET_BITS(OFFSET_BITS),
    .LINE_BITS  (LINE_BITS)
  ) u_extract (
    .lo_line(data_mem[lo_idx]),
    .hi_line(data_mem[hi_idx]),
    .offset (pc[OFFSET_BITS-1:0]),
    .word   (word)
  );

  always_comb begin
    state_next    = state_reg;
    inst_rdy_next = 1'b0;
    inst_out_next = inst_out_reg;
    mc_req_next   = mc_req_reg;
    mc_addr_next  = mc_addr_reg;
    install       = 1'b0;
    case (state_reg)
      ICACHE_IDLE: begin
        if (bus.next_inst && !bus.flush) begin
          if (lo_hit && hi_hit) begin
            inst_rdy_next = 1'b1;
            inst_out_next = word;
            state_next    = ICACHE_COOL;
          end else begin
            mc_req_next  = 1'b1;
            mc_addr_next = lo_hit ? hi_addr : lo_addr;
            state_next   = ICACHE_REFILL;
          end
        end
      end
      // A flush does not abort the refill; the line is still worth keeping.
      ICACHE_REFILL: begin
        if (bus.mc_line_rdy) begin
          install     = 1'b1;
          mc_req_next = 1'b0;
          state_next  = ICACHE_IDLE;
        end
      end
      ICACHE_COOL: state_next = ICACHE_IDLE;
      default:     state_next = ICACHE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_reg    <= ICACHE_IDLE;
      valid_reg    <= '0;
      inst_rdy_reg <= 1'b0;
      inst_out_reg <= '0;
      mc_req_reg   <= 1'b0;
      mc_addr_reg  <= '0;
    end else if (rdy_in) begin
      state_reg    <= state_next;
      inst_rdy_reg <= inst_rdy_next;
      inst_out_reg <= inst_out_next;
      mc_req_reg   <= mc_req_next;
      mc_addr_reg  <= mc_addr_next;
      if (install) valid_reg[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_in && rdy_in && install) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= bus.mc_line;
    end
  end

  assign bus.inst_rdy = inst_rdy_reg;
  assign bus.inst_out = inst_out_reg;
  assign bus.mc_req   = mc_req_reg;
  assign bus.mc_addr  = mc_addr_reg;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a memory responder serves refills, a monitor
// pops expected words and refill addresses from queues as the DUT emits them.
module tb_icache;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic rst_in, rdy_in;
  always #5 clk = ~clk;

  icache_if bus ();

  icache dut (
    .clk   (clk),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int pulse_cnt = 0;
  int last_pulse = 0;
  int inject_req = 0;
  int inject_ack = 0;
  logic resp_hold = 1'b0;
  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_req_q[$];

  always @(posedge clk) cycle++;

  // Backing memory contents: distinct per byte and per 256-byte page.
  function automatic logic [7:0] mb(input logic [31:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    for (int i = 0; i < 16; i++) l[i*8 +: 8] = mb(a + 32'(i));
    return l;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [31:0] w;
    logic [31:0] base;
    base = {pc[31:1], 1'b0};
    for (int i = 0; i < 4; i++) w[i*8 +: 8] = mb(base + 32'(i));
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pulse(input string name);
    int start;
    start = pulse_cnt;
    for (int n = 0; n < 200 && pulse_cnt == start; n++) cyc();
    if (pulse_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL %s: got no inst_rdy expected a pulse within 200 cycles", name);
    end
  endtask

  task automatic fetch(input logic [31:0] pc);
    bus.next_PC   = pc;
    bus.next_inst = 1'b1;
    exp_inst_q.push_back(word_at(pc));
    wait_pulse($sformatf("fetch_%h", pc));
  endtask

  task automatic idle();
    bus.next_inst = 1'b0;
    cyc();
  endtask

  // Memory controller model: answers a held request after 3 enabled cycles.
  initial begin
    int wait_cnt;
    wait_cnt        = 0;
    bus.mc_line_rdy = 1'b0;
    bus.mc_line     = '0;
    forever begin
      cyc();
      bus.mc_line_rdy = 1'b0;
      if (inject_req != inject_ack) begin
        bus.mc_line     = {4{32'hDEADBEEF}};
        bus.mc_line_rdy = 1'b1;
        inject_ack      = inject_req;
      end else if (bus.mc_req && rdy_in && !resp_hold) begin
        wait_cnt++;
        if (wait_cnt >= 3) begin
          bus.mc_line     = line_of(bus.mc_addr);
          bus.mc_line_rdy = 1'b1;
          wait_cnt        = 0;
        end
      end else if (!bus.mc_req) begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: compares every inst_rdy pulse and every new refill request.
  initial begin
    logic prev_rdy;
    logic prev_req;
    logic [31:0] e;
    prev_rdy = 1'b0;
    prev_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_in) begin
        prev_rdy = 1'b0;
        prev_req = 1'b0;
      end else begin
        if (bus.inst_rdy) begin
          pulse_cnt++;
          last_pulse = cycle;
          check("inst_rdy_not_back_to_back", 32'(prev_rdy), 32'd0);
          if (exp_inst_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_inst: got %h expected no pulse", bus.inst_out);
          end else begin
            e = exp_inst_q.pop_front();
            check("inst_out", bus.inst_out, e);
          end
        end
        if (bus.mc_req && !prev_req) begin
          if (exp_req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got mc_addr %h expected no request", bus.mc_addr);
          end else begin
            e = exp_req_q.pop_front();
            check("mc_addr", bus.mc_addr, e);
          end
        end
        prev_rdy = bus.inst_rdy;
        prev_req = bus.mc_req;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst_in        = 1'b1;
    rdy_in        = 1'b1;
    bus.next_PC   = '0;
    bus.next_inst = 1'b0;
    bus.flush     = 1'b0;
    repeat (3) cyc();
    rst_in = 1'b0;

    check("rst_inst_rdy", 32'(bus.inst_rdy), 32'd0);
    check("rst_inst_out", bus.inst_out, 32'd0);
    check("rst_mc_req", 32'(bus.mc_req), 32'd0);
    check("rst_mc_addr", bus.mc_addr, 32'd0);

    // Cold miss on line 0, hand-computed word
    exp_req_q.push_back(32'h0000_0000);
    bus.next_PC   = 32'h0;
    bus.next_inst = 1'b1;
    exp_inst_q.push_back(32'h3F3E_3D3C);
    wait_pulse("cold_fetch_0");

    // Hit stream: one pulse every second cycle
    t0 = last_pulse;
    fetch(32'h4);
    check("hit_gap_4", 32'(last_pulse - t0), 32'd2);
    t0 = last_pulse;
    fetch(32'h8);
    check("hit_gap_8", 32'(last_pulse - t0), 32'd2);
    idle();

    // Straddle over two cold lines
    exp_req_q.push_back(32'h10);
    exp_req_q.push_back(32'h20);
    fetch(32'h1E);
    idle();

    // Conflict eviction on index 0
    fetch(32'h000);
    exp_req_q.push_back(32'h100);
    fetch(32'h100);
    exp_req_q.push_back(32'h000);
    fetch(32'h000);
    idle();

    // Flush while refilling 0x40: line still installed, 0x80 served next
    resp_hold = 1'b1;
    exp_req_q.push_back(32'h40);
    bus.next_PC   = 32'h40;
    bus.next_inst = 1'b1;
    repeat (3) cyc();
    bus.flush   = 1'b1;
    bus.next_PC = 32'h80;
    cyc();
    bus.flush = 1'b0;
    resp_hold = 1'b0;
    exp_req_q.push_back(32'h80);
    exp_inst_q.push_back(word_at(32'h80));
    wait_pulse("after_flush_0x80");
    idle();
    fetch(32'h40);
    idle();

    // Freeze for 3 cycles mid-refill
    resp_hold = 1'b1;
    exp_req_q.push_back(32'hC0);
    bus.next_PC   = 32'hC0;
    bus.next_inst = 1'b1;
    repeat (2) cyc();
    rdy_in    = 1'b0;
    resp_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("frozen_mc_req", 32'(bus.mc_req), 32'd1);
      check("frozen_mc_addr", bus.mc_addr, 32'hC0);
      check("frozen_inst_rdy", 32'(bus.inst_rdy), 32'd0);
    end
    rdy_in = 1'b1;
    exp_inst_q.push_back(word_at(32'hC0));
    wait_pulse("after_freeze_0xC0");
    idle();

    // Reset mid-refill, then a stray line pulse that must be ignored
    resp_hold = 1'b1;
    exp_req_q.push_back(32'h200);
    bus.next_PC   = 32'h200;
    bus.next_inst = 1'b1;
    repeat (2) cyc();
    bus.next_inst = 1'b0;
    rst_in        = 1'b1;
    cyc();
    rst_in = 1'b0;
    check("rst_drops_mc_req", 32'(bus.mc_req), 32'd0);
    inject_req++;
    repeat (3) cyc();
    resp_hold = 1'b0;

    // Wrapping straddle; valid bits were cleared so both lines refill
    exp_req_q.push_back(32'hFFFF_FFF0);
    exp_req_q.push_back(32'h0000_0000);
    fetch(32'hFFFF_FFFE);
    idle();

    repeat (5) cyc();
    check("inst_queue_drained", 32'(exp_inst_q.size()), 32'd0);
    check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
